// File: rtl/fifo_w1_r16_64_if.sv
// fifo_w1_r16_64_if: bit-in / word-out port bundle for fifo_w1_r16_64; flush exists only with FIFO_W1_R16_FLUSH_EN
interface fifo_w1_r16_64_if #(
    parameter int WORD_DEPTH = 4
);
    logic din;
    logic wr_en;
    logic rd_en;
`ifdef FIFO_W1_R16_FLUSH_EN
    logic flush;
`endif
    logic [15:0] dout;
    logic full;
    logic empty;
    logic [3:0] bit_count;
    logic [$clog2(WORD_DEPTH):0] word_count;
    logic overflow;
    logic underflow;
`ifdef FIFO_W1_R16_FLUSH_EN
    modport master (output din, wr_en, rd_en, flush,
                    input dout, full, empty, bit_count, word_count, overflow, underflow);
    modport slave (input din, wr_en, rd_en, flush,
                   output dout, full, empty, bit_count, word_count, overflow, underflow);
`else
    modport master (output din, wr_en, rd_en,
                    input dout, full, empty, bit_count, word_count, overflow, underflow);
    modport slave (input din, wr_en, rd_en,
                   output dout, full, empty, bit_count, word_count, overflow, underflow);
`endif
endinterface

// File: rtl/fifo_w1_r16_64.sv
// fifo_w1_r16_64: packs a serial bitstream MSB-first into 16-bit words queued in a WORD_DEPTH-word FIFO
// Define FIFO_W1_R16_FLUSH_EN to add a flush input that zero-pads and pushes a partial word.
module fifo_w1_r16_64 #(
    parameter int WORD_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    fifo_w1_r16_64_if.slave bus
);
    localparam int AW = $clog2(WORD_DEPTH);
    localparam int CW = AW + 1;
    logic [15:0] mem [WORD_DEPTH];
    logic [14:0] shreg, shreg_nxt;
    logic [3:0] bit_cnt, cnt_nxt;
    logic [CW-1:0] wcnt;
    logic [AW-1:0] wp, rp;
    logic [15:0] dout_q, push_word;
    logic ovf, unf, full, empty, at_cap, accept, pop, push_bit, flush_push, flush_drop, push;
    assign at_cap = wcnt == CW'(WORD_DEPTH);
    assign full = at_cap && bit_cnt == 4'd15;
    assign empty = wcnt == '0;
    assign accept = bus.wr_en && !full;
    assign pop = bus.rd_en && !empty;
    assign push_bit = accept && bit_cnt == 4'd15;
    assign shreg_nxt = accept ? {shreg[13:0], bus.din} : shreg;
    assign cnt_nxt = accept ? bit_cnt + 4'd1 : bit_cnt;
`ifdef FIFO_W1_R16_FLUSH_EN
    // Flush acts on the partial word including this cycle's bit; a word completed by that bit needs no flush.
    assign flush_push = bus.flush && cnt_nxt != 4'd0 && !at_cap;
    assign flush_drop = bus.flush && cnt_nxt != 4'd0 && at_cap;
    assign push_word = push_bit ? {shreg, bus.din} : {1'b0, shreg_nxt} << (5'd16 - {1'b0, cnt_nxt});
`else
    assign flush_push = 1'b0;
    assign flush_drop = 1'b0;
    assign push_word = {shreg, bus.din};
`endif
    assign push = push_bit || flush_push;
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_word;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            bit_cnt <= '0;
            wcnt <= '0;
            wp <= '0;
            rp <= '0;
            dout_q <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            shreg <= push ? '0 : shreg_nxt;
            bit_cnt <= push ? 4'd0 : cnt_nxt;
            wcnt <= wcnt + CW'(push) - CW'(pop);
            wp <= push ? wp + AW'(1) : wp;
            rp <= pop ? rp + AW'(1) : rp;
            dout_q <= pop ? mem[rp] : dout_q;
            ovf <= ovf || (bus.wr_en && full) || flush_drop;
            unf <= unf || (bus.rd_en && empty);
        end
    end
    assign bus.dout = dout_q;
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.bit_count = bit_cnt;
    assign bus.word_count = wcnt;
    assign bus.overflow = ovf;
    assign bus.underflow = unf;
endmodule

// File: tb/tb_fifo_w1_r16_64.sv
// tb_fifo_w1_r16_64: randomized self-checking bench against a queue-based model of the packing FIFO
module tb_fifo_w1_r16_64;
    localparam int D = 4;
    localparam int CW = $clog2(D) + 1;
    localparam int VW = 24 + CW;
`ifdef FIFO_W1_R16_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    fifo_w1_r16_64_if #(.WORD_DEPTH(D)) bus();
    fifo_w1_r16_64 #(.WORD_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int failures = 0;
    bit part[$];
    logic [15:0] words[$];
    logic [15:0] m_dout;
    bit m_ovf, m_unf;

    function automatic logic [15:0] pack_bits();
        logic [15:0] w = '0;
        foreach (part[i]) w[15-i] = part[i];
        return w;
    endfunction

    function automatic logic [VW-1:0] m_vec();
        bit f = words.size() == D && part.size() == 15;
        return {m_dout, f, words.size() == 0, 4'(part.size()), CW'(words.size()), m_ovf, m_unf};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {bus.dout, bus.full, bus.empty, bus.bit_count, bus.word_count, bus.overflow, bus.underflow};
    endfunction

    task automatic drive_idle();
        bus.din = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
`ifdef FIFO_W1_R16_FLUSH_EN
        bus.flush = 1'b0;
`endif
    endtask

    task automatic step(input bit b, input bit wr, input bit rd, input bit fl);
        int occ;
        bit was_full;
        bus.din = b;
        bus.wr_en = wr;
        bus.rd_en = rd;
`ifdef FIFO_W1_R16_FLUSH_EN
        bus.flush = fl;
`endif
        @(posedge clk);
        occ = words.size();
        was_full = occ == D && part.size() == 15;
        if (rd) begin
            if (occ == 0) m_unf = 1'b1;
            else m_dout = words.pop_front();
        end
        if (wr) begin
            if (was_full) m_ovf = 1'b1;
            else part.push_back(b);
        end
        if (part.size() == 16) begin
            words.push_back(pack_bits());
            part.delete();
        end else if (HAS_FLUSH && fl && part.size() > 0) begin
            if (occ == D) m_ovf = 1'b1;
            else begin
                words.push_back(pack_bits());
                part.delete();
            end
        end
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        part.delete();
        words.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset();
        checks++; if (bus.dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.bit_count !== 4'd0) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", bus.bit_count); end
        checks++; if (bus.word_count !== CW'(0)) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", bus.word_count); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_basic_packing();
        logic [15:0] pat = 16'hA5C3;
        do_reset();
        for (int i = 0; i < 15; i++) step(pat[15-i], 1'b1, 1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL pack_empty15 got=%b exp=1", bus.empty); end
        step(pat[0], 1'b1, 1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL pack_empty16 got=%b exp=0", bus.empty); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.dout !== 16'hA5C3) begin failures++; $display("FAIL pack_dout got=%h exp=a5c3", bus.dout); end
        checks++; if (dut_vec() !== m_vec()) begin failures++; $display("FAIL pack_state got=%h exp=%h", dut_vec(), m_vec()); end
    endtask

    task automatic test_fill_to_full();
        do_reset();
        for (int i = 0; i < 79; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.full); end
        checks++; if (bus.word_count !== CW'(4)) begin failures++; $display("FAIL fill_word_count got=%0d exp=4", bus.word_count); end
        checks++; if (bus.bit_count !== 4'd15) begin failures++; $display("FAIL fill_bit_count got=%0d exp=15", bus.bit_count); end
        step(1'($urandom), 1'b1, 1'b1, 1'b0);
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow); end
        checks++; if (bus.word_count !== CW'(3)) begin failures++; $display("FAIL fill_word_count_after got=%0d exp=3", bus.word_count); end
        checks++; if (bus.bit_count !== 4'd15) begin failures++; $display("FAIL fill_bit_kept got=%0d exp=15", bus.bit_count); end
        checks++; if (dut_vec() !== m_vec()) begin failures++; $display("FAIL fill_state got=%h exp=%h", dut_vec(), m_vec()); end
        while (words.size() > 0) step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (dut_vec() !== m_vec()) begin failures++; $display("FAIL fill_drain got=%h exp=%h", dut_vec(), m_vec()); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.dout !== 16'h0000) begin failures++; $display("FAIL underflow_dout got=%h exp=0000", bus.dout); end
        checks++; if (bus.underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag got=%b exp=1", bus.underflow); end
        checks++; if (bus.empty !== 1'b1 || bus.word_count !== CW'(0)) begin failures++; $display("FAIL underflow_empty got=%b/%0d exp=1/0", bus.empty, bus.word_count); end
    endtask

    task automatic test_concurrent();
        int max_wc = 0;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            step(1'($urandom), 1'b1, c % 16 == 15, 1'b0);
            if (int'(bus.word_count) > max_wc) max_wc = int'(bus.word_count);
            checks++; if (dut_vec() !== m_vec()) begin failures++; $display("FAIL concurrent_c%0d got=%h exp=%h", c, dut_vec(), m_vec()); end
        end
        checks++; if (max_wc > 2) begin failures++; $display("FAIL concurrent_max_wc got=%0d exp<=2", max_wc); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w = 16'($urandom);
        do_reset();
        for (int i = 0; i < 41; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        checks++; if (bus.word_count !== CW'(2) || bus.bit_count !== 4'd9) begin failures++; $display("FAIL midrst_pre got=%0d/%0d exp=2/9", bus.word_count, bus.bit_count); end
        do_reset();
        checks++; if (dut_vec() !== {16'h0000, 1'b0, 1'b1, 4'd0, CW'(0), 2'b00}) begin failures++; $display("FAIL midrst_vals got=%h", dut_vec()); end
        for (int i = 0; i < 16; i++) step(w[15-i], 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.dout !== w) begin failures++; $display("FAIL midrst_word got=%h exp=%h", bus.dout, w); end
    endtask

`ifdef FIFO_W1_R16_FLUSH_EN
    task automatic test_flush();
        bit b5[5] = '{1, 1, 0, 1, 1};
        do_reset();
        foreach (b5[i]) step(b5[i], 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.bit_count !== 4'd0 || bus.word_count !== CW'(1)) begin failures++; $display("FAIL flush_counts got=%0d/%0d exp=0/1", bus.bit_count, bus.word_count); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.dout !== 16'hD800) begin failures++; $display("FAIL flush_dout got=%h exp=d800", bus.dout); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.word_count !== CW'(0) || bus.overflow !== 1'b0) begin failures++; $display("FAIL flush_noop got=%0d/%b exp=0/0", bus.word_count, bus.overflow); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.dout !== 16'hC000) begin failures++; $display("FAIL flush_samecycle got=%h exp=c000", bus.dout); end
        for (int i = 0; i < 15; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (dut_vec() !== m_vec() || bus.word_count !== CW'(1)) begin failures++; $display("FAIL flush_complete got=%h exp=%h", dut_vec(), m_vec()); end
        for (int i = 0; i < 51; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.overflow !== 1'b1 || bus.bit_count !== 4'd3 || bus.word_count !== CW'(4)) begin failures++; $display("FAIL flush_drop got=%b/%0d/%0d exp=1/3/4", bus.overflow, bus.bit_count, bus.word_count); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 500 == 499) do_reset();
            step(1'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, HAS_FLUSH && $urandom_range(0, 19) == 0);
            checks++; if (dut_vec() !== m_vec()) begin failures++; $display("FAIL random_c%0d got=%h exp=%h", c, dut_vec(), m_vec()); end
        end
    endtask

    initial begin
        drive_idle();
        m_dout = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #2;
        test_reset();
        test_basic_packing();
        test_fill_to_full();
        test_underflow();
        test_concurrent();
        test_reset_mid();
`ifdef FIFO_W1_R16_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_w1_r16_64.md
# fifo_w1_r16_64

Serial-to-parallel packing buffer: accepts one data bit per clock, assembles bits MSB-first into 16-bit words, and queues completed words in a 4-word (64-bit) FIFO for a 16-bit consumer. It sits on the capture path, the mirror of the 16-to-1 DAC output buffer. It turns serial ADC/comparator bitstreams into host-readable words. It runs in a single clock domain.

## Interface
- WORD_DEPTH, 4, word FIFO depth in 16-bit words; power of two, at least 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial data bit.
- wr_en  in  1  accept `din` this cycle.
- rd_en  in  1  pop one word.
- flush  in  1  present only with `FIFO_W1_R16_FLUSH_EN`; pushes a partial word.
- dout  out  16  read data word.
- full  out  1  the next bit cannot be accepted.
- empty  out  1  no complete word queued.
- bit_count  out  4  bits held in the current partial word (0–15).
- word_count  out  log2(WORD_DEPTH)+1  complete words queued.
- overflow  out  1  sticky; a write or flush was dropped.
- underflow  out  1  sticky; a read was attempted while empty.

## Operation
- **Reset values.** `rst` high at an edge sets `dout`=16'h0000, `empty`=1, `full`=0, `bit_count`=0, `word_count`=0, `overflow`=0 and `underflow`=0. It also clears the shift register and the read/write pointers. A partial word is discarded on reset mid-operation.
- **Bit acceptance.**
  - When `wr_en` is high and `full` is low, `din` shifts into the partial word and `bit_count` increments.
  - The first bit of a word becomes bit 15 and the 16th bit becomes bit 0 (MSB-first).
- **Word push.** When the accepted bit is the 16th, the assembled word is written to the FIFO on the same edge. `bit_count` wraps to 0 and `word_count` increments.
- **Full flag.**
  - `full` is combinational and equals (`word_count`==WORD_DEPTH) AND (`bit_count`==15).
  - Bits 0–14 of a new word are accepted while the FIFO is full.
  - A `wr_en` while `full` is high drops the bit: state is unchanged and `overflow` is set.
  - A same-cycle `rd_en` does not rescue the write.
- **Read.**
  - When `rd_en` is high and `empty` is low, the head word is registered into `dout` on that edge, the read pointer advances and `word_count` decrements.
  - `dout` holds its value until the next valid read.
  - `rd_en` while `empty` is high is ignored and sets `underflow`.
- **Empty flag.** `empty` is combinational and equals (`word_count`==0).
- **Simultaneous push and pop.** `word_count` is unchanged. Pointers wrap modulo WORD_DEPTH.
- **State machine.** The block has two states, FILL and PUSH, encoded implicitly by `bit_count`.
  - FILL covers `bit_count` 0–14 and is the state where bits accumulate.
  - PUSH covers `bit_count` 15: the next accepted bit completes the word and commits it, then the block returns to FILL at 0.

## Timing
- **Write-to-read latency.** The 16th bit is accepted at edge N. `empty` falls after edge N. The earliest `rd_en` is at edge N+1, and `dout` is valid after edge N+1.
- **Read latency.** `dout` changes on the edge that samples `rd_en` (standard-mode FIFO, not first-word-fall-through). The consumer samples `dout` in the cycle after asserting `rd_en`.
- **Throughput.** One bit per clock in. Up to one word per clock out.
- **Flag update.** Sticky flags assert on the offending edge and clear only on `rst`.

## Configuration
- **`FIFO_W1_R16_FLUSH_EN` defined:**
  - The `flush` port exists.
  - `flush` high with `bit_count`>0, taken after any same-cycle accepted bit, zero-pads the remaining LSBs, pushes the word and returns `bit_count` to 0.
  - If that same-cycle bit completes the word, only the normal push occurs.
  - Flush with `bit_count`=0 is a no-op.
  - Flush while `word_count`==WORD_DEPTH is dropped: the partial word is kept and `overflow` is set.
- **Undefined:** there is no `flush` port. Partial words are completed only by further bits or discarded by `rst`.

## Test plan
- **Basic packing.** After reset, stream bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with `wr_en`=1, then pulse `rd_en` → `empty` falls after the 16th bit and `dout`=16'hA5C3 one cycle after `rd_en`.
- **Fill to full.** Write 4×16+15=79 bits → `full`=1 with `word_count`=4 and `bit_count`=15. An 80th bit with `rd_en` in the same cycle → the bit is dropped, `overflow`=1 and `word_count`=3.
- **Underflow.** `rd_en` when empty at reset → `dout` stays 16'h0000 and `underflow`=1.
- **Concurrent push and pop.** Continuous writes with a read every 16 cycles over 200 cycles → `word_count` never exceeds 2, the words out equal the words in, and the pointers wrap correctly.
- **Reset mid-operation.** Assert `rst` after 9 bits and 2 queued words → all outputs return to reset values. The next 16 bits form the first word read.
- **Flush (macro defined).** Write 5 bits 1,1,0,1,1 then pulse `flush` → `dout`=16'hD800 on the next read and `bit_count`=0.
